kpn_channel_fifo: RTL
=====================

KPN_CHANNEL_FIFO -- requirements
Module: kpn_channel_fifo

Interface
REQ-001 SHALL provide parameter BITS_NUMBER, default 16, data word width in bits.
REQ-002 SHALL provide parameter FIFO_ELEMENTS, default 5, address width; depth = 2**FIFO_ELEMENTS (32 words).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port wr  input  1  write strobe from upstream queue stage, one word per high cycle.
REQ-006 SHALL provide port w_data  input  BITS_NUMBER  write data, sampled with wr.
REQ-007 SHALL provide port rd  input  1  read request from downstream process node.
REQ-008 SHALL provide port r_data  output  BITS_NUMBER  registered read data.
REQ-009 SHALL provide port r_valid  output  1  high for one cycle when r_data carries a newly read word.
REQ-010 SHALL provide port empty  output  1  no words stored.
REQ-011 SHALL provide port full  output  1  2**FIFO_ELEMENTS words stored.
REQ-012 SHALL provide port count  output  FIFO_ELEMENTS+1  number of stored words, 0..32.
REQ-013 SHALL provide port overflow  output  1  sticky: a write was dropped.
REQ-014 SHALL provide port underflow  output  1  sticky: a read was refused.

Function
REQ-015 SHALL accept a write (store w_data at w_ptr, w_ptr+1) when wr=1 and (full=0 or rd=1).
REQ-016 SHALL accept a read when rd=1 and empty=0: r_data <= mem[r_ptr], r_ptr+1, r_valid=1 next cycle; read latency 1 cycle.
REQ-017 SHALL hold r_data unchanged and drive r_valid=0 in any cycle without an accepted read.
REQ-018 SHALL wrap w_ptr and r_ptr modulo 2**FIFO_ELEMENTS (31 -> 0) without any other side effect.
REQ-019 SHALL update count: +1 write only, -1 read only, unchanged for both or neither.
REQ-020 SHALL derive empty = (count==0) and full = (count==2**FIFO_ELEMENTS), both registered-consistent with count.
REQ-021 Full with wr=1 and rd=1: SHALL accept both; oldest word read, new word written; count stays 32.
REQ-022 Empty with wr=1 and rd=1: SHALL accept write only, refuse read (no fall-through); count becomes 1; underflow set.
REQ-023 Full, wr=1, rd=0: SHALL drop the word, leave memory/pointers/count unchanged, set overflow.
REQ-024 Empty, rd=1, wr=0: SHALL leave state unchanged, r_valid=0, set underflow.
REQ-025 overflow and underflow SHALL remain set until reset.
REQ-026 Data SHALL pass unmodified; no arithmetic on w_data, bit-exact FIFO order.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force w_ptr=0, r_ptr=0, count=0, empty=1, full=0, r_data=0, r_valid=0, overflow=0, underflow=0.
REQ-028 Memory contents need not be cleared; reset mid-stream SHALL discard all stored words (empty=1).
REQ-029 First write SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 Reset then write 0x0001..0x0004 on 4 cycles, then rd 4 cycles -> r_data 0x0001..0x0004 each one cycle after rd, r_valid=1 x4, then empty=1, count=0.
REQ-031 Write 32 words 0x0100..0x011F -> full=1, count=32; 33rd wr with data 0xDEAD -> overflow=1, count=32; drain reads 0x0100..0x011F, 0xDEAD never appears.
REQ-032 At full, wr=1 rd=1 with 0xBEEF for one cycle -> r_data=0x0100, count=32; after draining, 0xBEEF is last word out.
REQ-033 From empty, wr=1 rd=1 with 0x1234 -> r_valid=0, underflow=1, count=1; next rd -> r_data=0x1234.
REQ-034 Fill 20, read 20, fill 20, read 20 -> pointers wrap past 31, all 40 words out in order, count ends 0.
REQ-035 Fill 10 words, pulse rst_n low between clk edges -> all outputs at reset values before next edge; empty=1, count=0 after release.

Source files
------------

// File: rtl/kpn_channel_fifo_if.sv
// Handshake bundle between an upstream writer, the channel FIFO and a downstream reader.
// The master modport is the upstream/downstream side; the slave modport is the FIFO.
interface kpn_channel_fifo_if #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
);
  logic                     wr;
  logic [BITS_NUMBER-1:0]   w_data;
  logic                     rd;
  logic [BITS_NUMBER-1:0]   r_data;
  logic                     r_valid;
  logic                     empty;
  logic                     full;
  logic [FIFO_ELEMENTS:0]   count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output wr, w_data, rd,
    input  r_data, r_valid, empty, full, count, overflow, underflow
  );

  modport slave (
    input  wr, w_data, rd,
    output r_data, r_valid, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/kpn_channel_fifo.sv
// Bounded KPN channel FIFO: registered one-cycle read, sticky overflow/underflow flags,
// simultaneous read+write allowed when full, no fall-through when empty.
module kpn_channel_fifo #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  kpn_channel_fifo_if.slave   bus
);
  localparam int DEPTH = 2 ** FIFO_ELEMENTS;
  localparam logic [FIFO_ELEMENTS:0] DEPTH_CNT = (FIFO_ELEMENTS + 1)'(DEPTH);
  localparam logic [FIFO_ELEMENTS:0] ONE_CNT   = (FIFO_ELEMENTS + 1)'(1);

  logic [BITS_NUMBER-1:0]   mem [DEPTH];
  logic [FIFO_ELEMENTS-1:0] w_ptr;
  logic [FIFO_ELEMENTS-1:0] r_ptr;
  logic [FIFO_ELEMENTS:0]   count_q;
  logic [FIFO_ELEMENTS:0]   count_next;
  logic                     empty_q;
  logic                     full_q;
  logic [BITS_NUMBER-1:0]   r_data_q;
  logic                     r_valid_q;
  logic                     overflow_q;
  logic                     underflow_q;
  logic                     do_wr;
  logic                     do_rd;

  // When full, a concurrent read frees the slot the write lands in, so both proceed.
  always_comb begin
    do_rd      = bus.rd && !empty_q;
    do_wr      = bus.wr && (!full_q || bus.rd);
    count_next = count_q;
    if (do_wr && !do_rd)
      count_next = count_q + ONE_CNT;
    else if (do_rd && !do_wr)
      count_next = count_q - ONE_CNT;
  end

  // Storage is not reset; the reset pointers and count make old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[w_ptr] <= bus.w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      r_data_q    <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_wr)
        w_ptr <= w_ptr + 1'b1;
      if (do_rd) begin
        r_data_q <= mem[r_ptr];
        r_ptr    <= r_ptr + 1'b1;
      end
      r_valid_q <= do_rd;
      count_q   <= count_next;
      empty_q   <= (count_next == '0);
      full_q    <= (count_next == DEPTH_CNT);
      if (bus.wr && !do_wr)
        overflow_q <= 1'b1;
      if (bus.rd && !do_rd)
        underflow_q <= 1'b1;
    end
  end

  assign bus.r_data    = r_data_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule
